jcounter_seq_ctrl: RTL and testbench

//  Step sequencer for a SIZE-bit Johnson (twisted-ring) counter, 2*SIZE phases.
//  Run a programmed step count, or run continuously, in either direction.

---
 rtl/jcounter_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_jcounter_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/jcounter_seq_ctrl.sv
// Step sequencer for a SIZE-bit Johnson ring: counted or continuous runs in either
// direction at one step per DIV clocks, with hold, stop and illegal-pattern recovery.
module jcounter_seq_ctrl #(
    parameter int SIZE = 4,
    parameter int DIV  = 4,
    parameter int CW   = 8,
    localparam int PW  = $clog2(2 * SIZE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            hold,
    input  logic            dir,
    input  logic            cont,
    input  logic [CW-1:0]   steps,
    output logic [SIZE-1:0] out,
    output logic [PW-1:0]   phase,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PHASE_MAX = PW'(2 * SIZE - 1);
    localparam logic [DW-1:0] PRE_TC    = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [SIZE-1:0] ring;
    logic [DW-1:0]   presc;
    logic [CW-1:0]   remaining;
    logic            dir_q;
    logic            cont_q;

    assign out = ring;

    // A Johnson code has at most one 0/1 boundary along the bit sequence.
    function automatic logic is_legal(input logic [SIZE-1:0] v);
        int edges;
        edges = 0;
        for (int i = 0; i < SIZE - 1; i++) begin
            if (v[i] != v[i+1]) edges++;
        end
        return (edges <= 1);
    endfunction

    function automatic logic [SIZE-1:0] step_fwd(input logic [SIZE-1:0] v);
        return {~v[0], v[SIZE-1:1]};
    endfunction

    function automatic logic [SIZE-1:0] step_rev(input logic [SIZE-1:0] v);
        return {v[SIZE-2:0], ~v[SIZE-1]};
    endfunction

    function automatic logic [PW-1:0] phase_fwd(input logic [PW-1:0] p);
        return (p == PHASE_MAX) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] phase_rev(input logic [PW-1:0] p);
        return (p == '0) ? PHASE_MAX : p - PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ring      <= '0;
            phase     <= '0;
            presc     <= '0;
            remaining <= '0;
            dir_q     <= 1'b0;
            cont_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (!is_legal(ring)) begin
                // Corrupted ring: force back to the origin and abandon any run.
                ring      <= '0;
                phase     <= '0;
                presc     <= '0;
                remaining <= '0;
                err       <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            dir_q     <= dir;
                            cont_q    <= cont;
                            remaining <= steps;
                            presc     <= '0;
                            if (!cont && steps == '0) begin
                                done <= 1'b1;
                            end else begin
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            remaining <= '0;
                        end else if (hold) begin
                            state <= HOLD;
                        end else if (presc == PRE_TC) begin
                            presc <= '0;
                            ring  <= dir_q ? step_rev(ring) : step_fwd(ring);
                            phase <= dir_q ? phase_rev(phase) : phase_fwd(phase);
                            if (!cont_q) begin
                                remaining <= remaining - CW'(1);
                                if (remaining == CW'(1)) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                        end else begin
                            presc <= presc + DW'(1);
                        end
                    end
                    HOLD: begin
                        if (stop) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            remaining <= '0;
                        end else if (!hold) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jcounter_seq_ctrl.sv
// Directed bench for jcounter_seq_ctrl: one instance with DIV=1 and one with DIV=4.
module tb_jcounter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       d1_start = 0, d1_stop = 0, d1_hold = 0, d1_dir = 0, d1_cont = 0;
    logic [7:0] d1_steps = '0;
    logic [3:0] d1_out;
    logic [2:0] d1_phase;
    logic       d1_busy, d1_done, d1_err;

    logic       d4_start = 0, d4_stop = 0, d4_hold = 0, d4_dir = 0, d4_cont = 0;
    logic [7:0] d4_steps = '0;
    logic [3:0] d4_out;
    logic [2:0] d4_phase;
    logic       d4_busy, d4_done, d4_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jcounter_seq_ctrl #(.SIZE(4), .DIV(1), .CW(8)) dut1 (
        .clk(clk), .reset(reset), .start(d1_start), .stop(d1_stop), .hold(d1_hold),
        .dir(d1_dir), .cont(d1_cont), .steps(d1_steps), .out(d1_out), .phase(d1_phase),
        .busy(d1_busy), .done(d1_done), .err(d1_err)
    );

    jcounter_seq_ctrl #(.SIZE(4), .DIV(4), .CW(8)) dut4 (
        .clk(clk), .reset(reset), .start(d4_start), .stop(d4_stop), .hold(d4_hold),
        .dir(d4_dir), .cont(d4_cont), .steps(d4_steps), .out(d4_out), .phase(d4_phase),
        .busy(d4_busy), .done(d4_done), .err(d4_err)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic       dir;
        logic [7:0] steps;
        logic [3:0] e_out;
        logic [2:0] e_phase;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    int ndone;
    int nchg;
    logic [3:0] prev;

    initial begin
        vecs[0]  = '{1, 0, 0, 8'd0,  4'b0000, 3'd0, 0, 0};
        vecs[1]  = '{0, 1, 0, 8'd3,  4'b0000, 3'd0, 1, 0};
        vecs[2]  = '{0, 1, 1, 8'd0,  4'b1000, 3'd1, 1, 0};
        vecs[3]  = '{0, 1, 1, 8'd0,  4'b1100, 3'd2, 1, 0};
        vecs[4]  = '{0, 1, 1, 8'd0,  4'b1110, 3'd3, 0, 1};
        vecs[5]  = '{0, 0, 0, 8'd0,  4'b1110, 3'd3, 0, 0};
        vecs[6]  = '{0, 1, 0, 8'd0,  4'b1110, 3'd3, 0, 1};
        vecs[7]  = '{0, 0, 0, 8'd0,  4'b1110, 3'd3, 0, 0};
        vecs[8]  = '{1, 0, 0, 8'd0,  4'b0000, 3'd0, 0, 0};
        vecs[9]  = '{0, 1, 1, 8'd1,  4'b0000, 3'd0, 1, 0};
        vecs[10] = '{0, 0, 0, 8'd0,  4'b0001, 3'd7, 0, 1};
        vecs[11] = '{0, 1, 0, 8'd1,  4'b0001, 3'd7, 1, 0};
        vecs[12] = '{0, 0, 0, 8'd0,  4'b0000, 3'd0, 0, 1};
        vecs[13] = '{0, 0, 0, 8'd0,  4'b0000, 3'd0, 0, 0};

        // Reset asserted in the middle of a run
        #2;
        reset = 1'b1;
        cyc();
        check("init_out", d1_out, 4'b0000);
        d1_start = 1; d1_steps = 8'd10; d1_dir = 0;
        cyc();
        d1_start = 0;
        repeat (3) cyc();
        check("pre_rst_out", d1_out, 4'b1110);
        reset = 1'b0;
        #1;
        check("rst_out", d1_out, 4'b0000);
        check("rst_phase", d1_phase, 3'd0);
        check("rst_busy", d1_busy, 1'b0);
        check("rst_done", d1_done, 1'b0);
        check("rst_err", d1_err, 1'b0);
        reset = 1'b1;
        cyc();
        check("post_rst_busy", d1_busy, 1'b0);
        check("post_rst_out", d1_out, 4'b0000);

        // Table: counted runs, start ignored while busy, zero-step start, single steps
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) pulse_reset();
            d1_start = vecs[i].start;
            d1_dir   = vecs[i].dir;
            d1_steps = vecs[i].steps;
            cyc();
            check($sformatf("v%0d_out", i), d1_out, vecs[i].e_out);
            check($sformatf("v%0d_phase", i), d1_phase, vecs[i].e_phase);
            check($sformatf("v%0d_busy", i), d1_busy, vecs[i].e_busy);
            check($sformatf("v%0d_done", i), d1_done, vecs[i].e_done);
            check($sformatf("v%0d_err", i), d1_err, 1'b0);
        end
        d1_start = 0;

        // Ten forward steps wrap through 0000
        d1_start = 1; d1_steps = 8'd10; d1_dir = 0;
        cyc();
        d1_start = 0;
        ndone = 0;
        for (int i = 1; i <= 14; i++) begin
            cyc();
            if (d1_done) ndone++;
            if (i == 8) check("wrap_out8", d1_out, 4'b0000);
            if (i == 10) begin
                check("wrap_done10", d1_done, 1'b1);
                check("wrap_busy10", d1_busy, 1'b0);
            end
        end
        check("wrap_out", d1_out, 4'b1100);
        check("wrap_phase", d1_phase, 3'd2);
        check("wrap_ndone", ndone, 1);

        // Illegal pattern injected while idle
        force dut1.ring = 4'b0101;
        #1;
        release dut1.ring;
        #1;
        check("ill_pre", d1_out, 4'b0101);
        cyc();
        check("ill_out", d1_out, 4'b0000);
        check("ill_phase", d1_phase, 3'd0);
        check("ill_err", d1_err, 1'b1);
        check("ill_busy", d1_busy, 1'b0);
        check("ill_done", d1_done, 1'b0);
        cyc();
        check("ill_err_clr", d1_err, 1'b0);
        check("ill_out2", d1_out, 4'b0000);

        // DIV=4 counted run of 5 steps with a 6-cycle hold
        d4_start = 1; d4_steps = 8'd5; d4_dir = 0; d4_cont = 0;
        cyc();
        d4_start = 0;
        repeat (3) cyc();
        check("lat_before", d4_out, 4'b0000);
        cyc();
        check("lat_first", d4_out, 4'b1000);
        repeat (2) cyc();
        d4_hold = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check($sformatf("hold%0d_out", i), d4_out, 4'b1000);
            check($sformatf("hold%0d_busy", i), d4_busy, 1'b1);
        end
        d4_hold = 0;
        ndone = 0;
        nchg = 1;
        prev = d4_out;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (d4_out != prev) nchg++;
            prev = d4_out;
            if (d4_done) ndone++;
        end
        check("hold_steps", nchg, 5);
        check("hold_ndone", ndone, 1);
        check("hold_out", d4_out, 4'b0111);
        check("hold_phase", d4_phase, 3'd5);
        check("hold_busy", d4_busy, 1'b0);

        // DIV=4 continuous reverse run, stopped on a tick edge
        d4_start = 1; d4_cont = 1; d4_dir = 1; d4_steps = 8'd0;
        cyc();
        d4_start = 0;
        ndone = 0;
        for (int i = 0; i < 11; i++) begin
            cyc();
            if (d4_done) ndone++;
        end
        check("cont_busy", d4_busy, 1'b1);
        check("cont_out", d4_out, 4'b1110);
        check("cont_phase", d4_phase, 3'd3);
        d4_stop = 1;
        cyc();
        d4_stop = 0;
        if (d4_done) ndone++;
        check("stop_busy", d4_busy, 1'b0);
        check("stop_out", d4_out, 4'b1110);
        check("stop_phase", d4_phase, 3'd3);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (d4_done) ndone++;
        end
        check("stop_retained", d4_out, 4'b1110);
        check("stop_idle", d4_busy, 1'b0);
        check("stop_ndone", ndone, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
